// File: rtl/controller_poller.sv
// controller_poller -- host-side reader for the two serial game controllers.
// On a start tick it strobes controller_latch for LATCH_TICKS ticks, then
// drives controller_clk_enable for 8 ticks while shifting in both active-low
// serial streams MSB-first. Button outputs change only when a whole byte is in,
// so a CPU read mid-poll never sees a partial byte.
//
// Ports:
//   clk_1, rst_B              CPU clock, async active-low reset
//   clk_enable                tick qualifier; state only advances on ticks
//   start                     poll request (honoured only in IDLE)
//   controller_latch          latch strobe to both controllers (registered)
//   controller_clk_enable     shift strobe (SHIFT state AND clk_enable)
//   controller_{1,2}_data_in_B serial data, active-low
//   controller_{1,2}_buttons_out last complete byte, active-high
//   busy                      poll in progress
//   valid                     one-cycle pulse when the button outputs update

// Per-controller shift register and held output byte.
module controller_poller_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             load_en,
  input  logic             data_b,
  output logic [VEC_W-1:0] buttons
);
  logic [VEC_W-1:0] sr;
  logic [VEC_W-1:0] sr_nxt;

  // MSB-first: earlier bits walk up toward bit VEC_W-1.
  assign sr_nxt = {sr[VEC_W-2:0], ~data_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      buttons <= '0;
    end else if (shift_en) begin
      sr <= sr_nxt;
      // Final bit goes straight into the output so the byte lands with valid.
      if (load_en) buttons <= sr_nxt;
    end
  end
endmodule

module controller_poller #(
  parameter int LATCH_TICKS = 1
) (
  input  logic       clk_1,
  input  logic       rst_B,
  input  logic       clk_enable,
  input  logic       start,
  output logic       controller_latch,
  output logic       controller_clk_enable,
  input  logic       controller_1_data_in_B,
  input  logic       controller_2_data_in_B,
  output logic [7:0] controller_1_buttons_out,
  output logic [7:0] controller_2_buttons_out,
  output logic       busy,
  output logic       valid
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT} state_t;

  state_t     state, state_nxt;
  logic [3:0] latch_cnt;
  logic [2:0] bit_cnt;
  logic       shift_tick;
  logic       last_tick;

  logic [NUM_LANES-1:0]            data_b;
  logic [NUM_LANES-1:0][VEC_W-1:0] buttons;

  assign shift_tick = (state == SHIFT) && clk_enable;
  assign last_tick  = shift_tick && (bit_cnt == 3'd7);

  // Controllers shift on the same edge we sample, so each edge captures the
  // bit that was presented before it.
  assign controller_clk_enable = shift_tick;

  always_ff @(posedge clk_1 or negedge rst_B) begin
    if (!rst_B) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clk_enable && start)               state_nxt = LATCH;
      LATCH:   if (clk_enable && (latch_cnt == 4'd0)) state_nxt = SHIFT;
      SHIFT:   if (last_tick)                         state_nxt = IDLE;
      default:                                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst_B) begin
    if (!rst_B) begin
      latch_cnt        <= 4'd0;
      bit_cnt          <= 3'd0;
      controller_latch <= 1'b0;
      busy             <= 1'b0;
      valid            <= 1'b0;
    end else begin
      // Registered decodes of the next state; they track state exactly.
      controller_latch <= (state_nxt == LATCH);
      busy             <= (state_nxt != IDLE);
      valid            <= last_tick;
      if (clk_enable) begin
        case (state)
          IDLE: if (start) begin
            latch_cnt <= 4'(LATCH_TICKS - 1);
            bit_cnt   <= 3'd0;
          end
          LATCH: if (latch_cnt != 4'd0) latch_cnt <= latch_cnt - 4'd1;
          SHIFT: bit_cnt <= bit_cnt + 3'd1;  // wraps 7 -> 0 on exit
          default: ;
        endcase
      end
    end
  end

  assign data_b = {controller_2_data_in_B, controller_1_data_in_B};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    controller_poller_lane #(.VEC_W(VEC_W)) u_lane (
      .clk      (clk_1),
      .rst_n    (rst_B),
      .shift_en (shift_tick),
      .load_en  (last_tick),
      .data_b   (data_b[i]),
      .buttons  (buttons[i])
    );
  end

  assign controller_1_buttons_out = buttons[0];
  assign controller_2_buttons_out = buttons[1];
endmodule

// File: tb/tb_controller_poller.sv
module tb_controller_poller;
  logic clk_1 = 1'b0;
  logic rst_B, clk_enable, start;
  logic [7:0] pat1, pat2;

  // DUT a: default LATCH_TICKS; DUT b: LATCH_TICKS=3.
  logic latch_a, cen_a, busy_a, valid_a, d1a, d2a;
  logic latch_b, cen_b, busy_b, valid_b, d1b, d2b;
  logic [7:0] o1a, o2a, o1b, o2b;
  logic [7:0] m1a = '0, m2a = '0, m1b = '0, m2b = '0;

  int checks = 0, errors = 0;
  int vcnt_a, vcnt_b, lt_a, lt_b, ct_a, ct_b, bt_a, bt_b, ovl;
  int la, lb;

  always #5 clk_1 = ~clk_1;

  controller_poller dut_a (
    .clk_1(clk_1), .rst_B(rst_B), .clk_enable(clk_enable), .start(start),
    .controller_latch(latch_a), .controller_clk_enable(cen_a),
    .controller_1_data_in_B(d1a), .controller_2_data_in_B(d2a),
    .controller_1_buttons_out(o1a), .controller_2_buttons_out(o2a),
    .busy(busy_a), .valid(valid_a));

  controller_poller #(.LATCH_TICKS(3)) dut_b (
    .clk_1(clk_1), .rst_B(rst_B), .clk_enable(clk_enable), .start(start),
    .controller_latch(latch_b), .controller_clk_enable(cen_b),
    .controller_1_data_in_B(d1b), .controller_2_data_in_B(d2b),
    .controller_1_buttons_out(o1b), .controller_2_buttons_out(o2b),
    .busy(busy_b), .valid(valid_b));

  // controller_m models: load while latched, shift MSB-out on strobe edges.
  assign d1a = ~m1a[7];
  assign d2a = ~m2a[7];
  assign d1b = ~m1b[7];
  assign d2b = ~m2b[7];
  always @(posedge clk_1) begin
    if (latch_a) begin m1a <= pat1; m2a <= pat2; end
    else if (cen_a) begin m1a <= {m1a[6:0], 1'b0}; m2a <= {m2a[6:0], 1'b0}; end
    if (latch_b) begin m1b <= pat1; m2b <= pat2; end
    else if (cen_b) begin m1b <= {m1b[6:0], 1'b0}; m2b <= {m2b[6:0], 1'b0}; end
  end

  // Strobe/tick accounting: values at the falling edge describe the next rising edge.
  always @(negedge clk_1) begin
    if (valid_a) vcnt_a++;
    if (valid_b) vcnt_b++;
    if (latch_a && clk_enable) lt_a++;
    if (latch_b && clk_enable) lt_b++;
    if (cen_a) ct_a++;
    if (cen_b) ct_b++;
    if (busy_a && clk_enable) bt_a++;
    if (busy_b && clk_enable) bt_b++;
    if ((latch_a && cen_a) || (latch_b && cen_b)) ovl++;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_1);
    #1;
  endtask

  task automatic clr;
    vcnt_a = 0; vcnt_b = 0; lt_a = 0; lt_b = 0; ct_a = 0; ct_b = 0;
    bt_a = 0; bt_b = 0; ovl = 0;
  endtask

  // One poll: start sampled at T0, then `cycles` clk_1 cycles. Outputs must
  // hold `hold` until each DUT's valid. restart_at re-asserts start on that cycle.
  task automatic poll(input int cycles, input bit gate, input int restart_at,
                      input logic [15:0] hold, output int lat_a, output int lat_b);
    clr();
    clk_enable = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    lat_a = 0; lat_b = 0;
    for (int c = 1; c <= cycles; c++) begin
      clk_enable = gate ? (c % 2 == 0) : 1'b1;
      start = (c == restart_at);
      tick();
      if (valid_a && lat_a == 0) lat_a = c;
      if (valid_b && lat_b == 0) lat_b = c;
      if (lat_a == 0) chk("hold_a", {o1a, o2a}, hold);
      if (lat_b == 0) chk("hold_b", {o1b, o2b}, hold);
    end
    clk_enable = 1'b1; start = 1'b0;
  endtask

  initial begin
    rst_B = 1'b0; clk_enable = 1'b1; start = 1'b0;
    pat1 = 8'b10001001; pat2 = 8'b00100110;
    clr();
    #3;
    chk("rst_outs_a", {o1a, o2a, latch_a, cen_a, busy_a, valid_a}, '0);
    chk("rst_outs_b", {o1b, o2b, latch_b, cen_b, busy_b, valid_b}, '0);
    @(negedge clk_1); @(negedge clk_1);
    rst_B = 1'b1;
    tick();
    chk("idle_busy", {busy_a, busy_b}, 0);

    // Single poll / strobe shape
    poll(16, 1'b0, 0, 16'h0000, la, lb);
    chk("lat_a", la, 9);
    chk("lat_b", lb, 11);
    chk("bytes_a", {o1a, o2a}, 16'h8926);
    chk("bytes_b", {o1b, o2b}, 16'h8926);
    chk("valid_cnt_a", vcnt_a, 1);
    chk("valid_cnt_b", vcnt_b, 1);
    chk("busy_ticks_a", bt_a, 9);
    chk("busy_ticks_b", bt_b, 11);
    chk("latch_ticks_a", lt_a, 1);
    chk("latch_ticks_b", lt_b, 3);
    chk("cen_ticks_a", ct_a, 8);
    chk("cen_ticks_b", ct_b, 8);
    chk("overlap", ovl, 0);

    // No tearing: old byte held for the whole poll, new one arrives with valid
    pat1 = 8'hFF;
    poll(16, 1'b0, 0, 16'h8926, la, lb);
    chk("tear_lat_a", la, 9);
    chk("tear_lat_b", lb, 11);
    chk("tear_bytes_a", {o1a, o2a}, 16'hFF26);
    chk("tear_bytes_b", {o1b, o2b}, 16'hFF26);

    // Start while busy is ignored
    pat1 = 8'h89;
    poll(16, 1'b0, 4, 16'hFF26, la, lb);
    chk("busy_start_valid_a", vcnt_a, 1);
    chk("busy_start_valid_b", vcnt_b, 1);
    chk("busy_start_latch_a", lt_a, 1);
    chk("busy_start_latch_b", lt_b, 3);
    chk("busy_start_bytes_a", {o1a, o2a}, 16'h8926);

    // Start coinciding with dut_a's final SHIFT tick is ignored
    poll(16, 1'b0, 9, 16'h8926, la, lb);
    chk("final_start_valid_a", vcnt_a, 1);
    chk("final_start_latch_a", lt_a, 1);
    chk("final_start_busy_a", busy_a, 0);

    // Clock-enable gating: every other cycle is a tick
    poll(30, 1'b1, 0, 16'h8926, la, lb);
    chk("gate_lat_a", la, 18);
    chk("gate_lat_b", lb, 22);
    chk("gate_bytes_a", {o1a, o2a}, 16'h8926);
    chk("gate_bytes_b", {o1b, o2b}, 16'h8926);
    chk("gate_cen_a", ct_a, 8);
    chk("gate_valid_a", vcnt_a, 1);

    // Reset during dut_a's third SHIFT tick cycle
    clk_enable = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_cen_a", cen_a, 1);
    #2;
    rst_B = 1'b0;
    #1;
    chk("midrst_a", {o1a, o2a, latch_a, cen_a, busy_a, valid_a}, '0);
    chk("midrst_b", {o1b, o2b, latch_b, cen_b, busy_b, valid_b}, '0);
    @(negedge clk_1);
    rst_B = 1'b1;
    tick();
    poll(16, 1'b0, 0, 16'h0000, la, lb);
    chk("post_rst_lat_a", la, 9);
    chk("post_rst_bytes_a", {o1a, o2a}, 16'h8926);
    chk("post_rst_bytes_b", {o1b, o2b}, 16'h8926);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/controller_poller.md
# controller_poller

Host-side reader for the two serial game controllers. On request, it drives the latch and clock-enable lines that `controller_m` responds to and shifts in both active-low serial data streams in parallel. It then presents the two 8-bit button bytes to the CPU-facing register logic. It sits inside `top_m` beside the controller address decode and runs in the CPU clock domain.

## Interface
Parameters:
- `LATCH_TICKS`, default 1: number of enabled ticks for which `controller_latch` is held high. Legal range is 1–15.

Ports:
- `clk_1`  in  1: CPU clock. This is the only clock.
- `rst_B`  in  1: reset, asynchronous, active-low.
- `clk_enable`  in  1: tick qualifier. State advances only on `clk_1` rising edges where `clk_enable`=1.
- `start`  in  1: poll request, sampled on a tick.
- `controller_latch`  out  1: latch/load strobe to both controllers.
- `controller_clk_enable`  out  1: shift strobe to both controllers. Each controller shifts on a `clk_1` edge while this is 1.
- `controller_1_data_in_B`  in  1: serial data from controller 1, active-low.
- `controller_2_data_in_B`  in  1: serial data from controller 2, active-low.
- `controller_1_buttons_out`  out  8: last complete byte from controller 1, active-high (1 = pressed).
- `controller_2_buttons_out`  out  8: last complete byte from controller 2, active-high.
- `busy`  out  1: high while a poll is in progress.
- `valid`  out  1: one-`clk_1`-cycle pulse when the button outputs update.

## Operation
- State machine has three states: IDLE, LATCH, SHIFT.
- IDLE:
  - A tick with `start`=1 moves to LATCH, loads the latch counter with `LATCH_TICKS-1`, and clears the bit counter.
  - `start` is ignored in any other state. There is no queuing.
- LATCH:
  - `controller_latch`=1 for the whole state.
  - Each tick decrements the latch counter. On the tick where it reads 0, the block moves to SHIFT.
- SHIFT (exactly 8 ticks):
  - `controller_clk_enable` = `clk_enable`.
  - Each tick samples both data lines with inversion into the two shift registers.
  - Sampling is MSB-first: the first bit received ends in bit 7, the eighth in bit 0.
  - The sample and the controller shift happen on the same edge, so each edge captures the bit presented before it.
  - The 3-bit counter runs 0..7. On the tick where it reads 7:
    - the outputs are loaded from the final shift value;
    - `valid` goes to 1;
    - the state returns to IDLE.
- `busy` = (state != IDLE).
- The button outputs hold their previous value for the whole poll. A CPU read during a poll never sees a partial byte.
- `valid` clears on the next `clk_1` edge regardless of `clk_enable`.
- All outputs are registered except `controller_clk_enable`, which is a combinational AND of the SHIFT state and `clk_enable`.

## Timing
- Reset values (`rst_B`=0, immediate and asynchronous):
  - state IDLE;
  - `controller_latch`=0, `controller_clk_enable`=0, `busy`=0, `valid`=0;
  - both button outputs 8'h00;
  - both counters 0.
- Reset in mid-poll aborts the poll. The button outputs are cleared, not held.
- Latency, counted in ticks from the tick that samples `start` (T0) to the edge that updates the outputs and raises `valid`: `LATCH_TICKS` + 8. With the default this is 9 ticks.
- `controller_latch` is high for exactly `LATCH_TICKS` ticks.
- `controller_clk_enable` is high for exactly 8 ticks, always after latch falls. The two are never high in the same cycle.
- A `start` held high re-arms on the first IDLE tick after `valid`. Polls therefore run back-to-back with a 1-tick IDLE gap.
- When `clk_enable`=0 mid-poll, everything freezes:
  - no state change;
  - `controller_clk_enable`=0;
  - outputs steady.
- Start-poll boundary: if `start` and the final SHIFT tick coincide, `start` is ignored. Only a start sampled in IDLE counts.

## Test plan
- **Single poll.** `controller_m` model 1 holds 8'b10001001 and model 2 holds 8'b00100110. Pulse `start` for one tick. Required response:
  - after 9 ticks, `controller_1_buttons_out`=8'h89 and `controller_2_buttons_out`=8'h26;
  - `valid` pulses for 1 cycle;
  - `busy` is high for exactly 9 ticks.
- **Strobe shape.** With `LATCH_TICKS`=3: latch is high for 3 ticks, then `controller_clk_enable` is high for 8 ticks, with no overlap. `valid` follows 11 ticks after start.
- **No tearing.** After a poll returns 8'h89, change the model to 8'hFF and start a new poll. Required response:
  - reads at every tick during the poll return 8'h89;
  - 8'hFF appears only with `valid`.
- **Start while busy.** Pulse `start` again 4 ticks into a poll. Exactly one `valid` is produced and no second latch occurs.
- **Clock-enable gating.** Toggle `clk_enable` 1/0 every cycle during a poll. Results are identical to the single-poll case, and latency is 18 `clk_1` cycles.
- **Reset mid-SHIFT.** Drop `rst_B` at the third SHIFT tick. Required response:
  - all outputs go to 0 in the same cycle;
  - after release, a fresh `start` yields 8'h89/8'h26 correctly.
